// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state type and width helper for serial_adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Never returns 0 so a single-beat configuration still gets a 1-bit counter.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// rtl/serial_adder_full_adder.sv - 1-bit sum/carry cell used as the beat ripple chain
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - STEP-bits-per-beat serial adder with valid/ready; SERIAL_ADDER_SUB_EN enables a - b
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [STEP:0]    chain;
  logic [STEP-1:0]  beat_sum;
  logic [WIDTH-1:0] b_in;
  logic             carry_in;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_in     = sub ? ~b : b;
  assign carry_in = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_in       = b;
  assign carry_in   = cin;
`endif

  assign chain[0] = carry_q;
  for (genvar i = 0; i < STEP; i++) begin : g_fa
    full_adder u_fa (
      .a_i (a_q[i]),
      .b_i (b_q[i]),
      .c_i (chain[i]),
      .s_o (beat_sum[i]),
      .c_o (chain[i+1])
    );
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_in;
          carry_d = carry_in;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> STEP;
        b_d     = b_q >> STEP;
        // result bits enter at the top so the first beat ends up in the LSBs
        sum_d   = WIDTH'({beat_sum, sum_q} >> STEP);
        carry_d = chain[STEP];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cout_d      = chain[STEP];
          ovf_d       = chain[STEP] ^ chain[STEP-1];
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (8x1 and 16x4 instances)
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       iv0, ir0, ov0, or0, cin0, sub0, co0, of0;
  logic [7:0] a0, b0, s0;
  logic        iv1, ir1, ov1, or1, cin1, sub1, co1, of1;
  logic [15:0] a1, b1, s1;

  serial_adder #(.WIDTH(8), .STEP(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .cin(cin0), .sub(sub0), .out_valid(ov0), .out_ready(or0), .sum(s0),
    .cout(co0), .overflow(of0));

  serial_adder #(.WIDTH(16), .STEP(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(s1),
    .cout(co1), .overflow(of1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer addition; overflow from operand/result signs.
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
    logic [15:0] mask, bb, s;
    logic [16:0] full;
    logic c, co, ov;
    mask = 16'((17'd1 << w) - 17'd1);
    bb = b & mask;
    c = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      bb = ~b & mask;
      c  = 1'b1;
    end
`endif
    full = {1'b0, a & mask} + {1'b0, bb} + {16'd0, c};
    s  = full[15:0] & mask;
    co = full[w];
    ov = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  // Latency is measured in clock edges after the accept edge (DONE state = cycle T0+N+1).
  task automatic run_op(input int inst, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic sb, input bit finish_hs,
                        output logic [15:0] s, output logic co, output logic ov, output int lat);
    int t;
    t = 0;
    while (!(inst == 0 ? ir0 : ir1) && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    if (inst == 0) begin
      iv0 = 1'b1; a0 = a[7:0]; b0 = b[7:0]; cin0 = c; sub0 = sb;
    end else begin
      iv1 = 1'b1; a1 = a; b1 = b; cin1 = c; sub1 = sb;
    end
    @(posedge clk); #1;
    iv0 = 1'b0; iv1 = 1'b0;
    lat = 0;
    while (!(inst == 0 ? ov0 : ov1) && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    s  = (inst == 0) ? {8'h00, s0} : s1;
    co = (inst == 0) ? co0 : co1;
    ov = (inst == 0) ? of0 : of1;
    if (finish_hs) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] s;
    logic       co, ov;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [15:0] rs, ra, rb, held_s;
    logic rco, rov, rc, rsb, held_co, held_ov;
    logic [17:0] e;
    int lat;

    tbl[0] = '{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
`ifdef SERIAL_ADDER_SUB_EN
    tbl[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
`else
    tbl[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0};
`endif
    tbl[4] = '{8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

    rst_n = 1'b0;
    iv0 = 0; a0 = 0; b0 = 0; cin0 = 0; sub0 = 0; or0 = 1;
    iv1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; or1 = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", {31'd0, ir0}, 32'd1);
    check("rst out_valid", {31'd0, ov0}, 32'd0);
    check("rst sum", {24'd0, s0}, 32'd0);
    check("rst cout", {31'd0, co0}, 32'd0);
    check("rst overflow", {31'd0, of0}, 32'd0);
    check("rst16 in_ready", {31'd0, ir1}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_op(0, {8'h00, tbl[i].a}, {8'h00, tbl[i].b}, tbl[i].cin, tbl[i].sub, 1'b1, rs, rco, rov, lat);
      check($sformatf("tbl%0d sum", i), {16'd0, rs}, {24'd0, tbl[i].s});
      check($sformatf("tbl%0d cout", i), {31'd0, rco}, {31'd0, tbl[i].co});
      check($sformatf("tbl%0d ovf", i), {31'd0, rov}, {31'd0, tbl[i].ov});
      check($sformatf("tbl%0d latency", i), lat, 32'd8);
      check($sformatf("tbl%0d in_ready after hs", i), {31'd0, ir0}, 32'd1);
    end

    // Abort mid-RUN: sum already holds partial non-zero bits, cout=1 from the last op.
    iv0 = 1'b1; a0 = 8'hAA; b0 = 8'h55; cin0 = 0; sub0 = 0;
    @(posedge clk); #1;
    iv0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", {31'd0, ov0}, 32'd0);
    check("abort sum", {24'd0, s0}, 32'd0);
    check("abort cout", {31'd0, co0}, 32'd0);
    check("abort overflow", {31'd0, of0}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post-abort no result", {31'd0, ov0}, 32'd0);
    check("post-abort in_ready", {31'd0, ir0}, 32'd1);
    run_op(0, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b1, rs, rco, rov, lat);
    check("post-abort sum", {16'd0, rs}, 32'h30);

    // Back-pressure in DONE: outputs frozen, new operands ignored.
    or0 = 1'b0;
    run_op(0, 16'h0033, 16'h0044, 1'b0, 1'b0, 1'b0, held_s, held_co, held_ov, lat);
    check("stall sum", {16'd0, held_s}, 32'h77);
    for (int k = 0; k < 5; k++) begin
      iv0 = 1'b1; a0 = 8'h11 * k[7:0]; b0 = 8'hF0;
      @(posedge clk); #1;
      check($sformatf("stall%0d out_valid", k), {31'd0, ov0}, 32'd1);
      check($sformatf("stall%0d in_ready", k), {31'd0, ir0}, 32'd0);
      check($sformatf("stall%0d sum", k), {24'd0, s0}, 32'h77);
      check($sformatf("stall%0d cout", k), {31'd0, co0}, {31'd0, held_co});
      check($sformatf("stall%0d ovf", k), {31'd0, of0}, {31'd0, held_ov});
    end
    iv0 = 1'b0;
    or0 = 1'b1;
    @(posedge clk); #1;
    check("release in_ready", {31'd0, ir0}, 32'd1);
    check("release out_valid", {31'd0, ov0}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("ignored in_valid no op", {31'd0, ov0}, 32'd0);

    run_op(1, 16'h1234, 16'h0FFF, 1'b1, 1'b0, 1'b1, rs, rco, rov, lat);
    check("w16 sum", {16'd0, rs}, 32'h2234);
    check("w16 cout", {31'd0, rco}, 32'd0);
    check("w16 ovf", {31'd0, rov}, 32'd0);
    check("w16 latency", lat, 32'd4);

    for (int i = 0; i < 60; i++) begin
      int inst, w;
      inst = i % 2;
      w = (inst == 0) ? 8 : 16;
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rsb = 1'($urandom);
      if (inst == 0) begin
        ra[15:8] = 8'h00; rb[15:8] = 8'h00;
      end
      e = ref_add(w, ra, rb, rc, rsb);
      run_op(inst, ra, rb, rc, rsb, 1'b1, rs, rco, rov, lat);
      check($sformatf("rnd%0d sum a=%0h b=%0h", i, ra, rb), {16'd0, rs}, {16'd0, e[15:0]});
      check($sformatf("rnd%0d cout", i), {31'd0, rco}, {31'd0, e[16]});
      check($sformatf("rnd%0d ovf", i), {31'd0, rov}, {31'd0, e[17]});
      check($sformatf("rnd%0d latency", i), lat, (inst == 0) ? 32'd8 : 32'd4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Multi-cycle, parametrised adder that consumes two WIDTH-bit operands and produces their sum STEP bits per clock using a single registered carry. Successor to the combinational half/full adder cells: the same carry-chain arithmetic, generalised in width, time-multiplexed over cycles and wrapped in a valid/ready handshake. It is the ALU's area-cheap adder path for the CPU datapath and is driven by the control sequencer.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- STEP, 1, bits added per cycle; WIDTH must be an integer multiple of STEP.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- One clock; reset is asynchronous and active-low.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; add mode only.
- sub  input  1  subtract request; honoured only with SERIAL_ADDER_SUB_EN.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE; beats N = WIDTH/STEP.
- IDLE: in_ready=1. On in_valid: latch a, b (b inverted when subtracting), carry ← cin (← 1 when subtracting), beat counter ← 0, go RUN.
- RUN: in_ready=0. Each cycle add the STEP LSBs of the A/B shift registers plus carry. Shift A/B right by STEP. Shift the STEP result bits into the top of the sum register. Update carry. Increment counter.
- On the beat with counter = N-1: capture cout and overflow, go DONE.
- DONE: out_valid=1; sum/cout/overflow held stable until out_valid && out_ready. On the handshake go IDLE.
- No accept in DONE: in_ready returns to 1 the cycle after the output handshake.
- in_valid while not IDLE: ignored, operand inputs not sampled.
- Arithmetic is modulo 2^WIDTH. cin is ignored in subtract mode.
- Overflow for STEP=1 uses the carry into the last bit. For STEP>1 it is computed inside the final beat's adder.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, carry=0, counter=0.
- Accept edge T0 (in_valid && in_ready). RUN occupies cycles T0+1 … T0+N. out_valid is high from T0+N+1.
- Latency: N+1 cycles from accept to result. Throughput: one operation per N+2 cycles at best (out_ready held high).
- sum is not valid, and may change, while out_valid=0.
- rst_n asserted at any time, including mid-RUN or during DONE: the operation is aborted immediately, outputs take reset values, and no result is delivered.
- All outputs are registered except in_ready, which decodes state.

## Configuration
- SERIAL_ADDER_SUB_EN defined: sub=1 at accept computes a − b as a + ~b + 1. cout=1 means no borrow; overflow follows the signed subtraction rule.
- SERIAL_ADDER_SUB_EN undefined: the sub port is present but ignored (treated as 0), and no inversion logic is built.

## Structure
- Package serial_adder_pkg holds:
  - the state typedef (IDLE/RUN/DONE);
  - helper function clog2 for counter width.
- Sub-module full_adder: 1-bit sum/carry cell. It is instantiated STEP times as a ripple chain inside the beat datapath.
- Top level contains: FSM, beat counter, A/B/sum shift registers, carry flop.

## Test plan
- WIDTH=8, STEP=1; a=0x01, b=0x01, cin=0 → out_valid 9 cycles after accept, sum=0x02, cout=0, overflow=0.
- a=0xFF, b=0x01 → sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x01 → sum=0x80, cout=0, overflow=1.
- Hold out_ready=0 for 5 cycles in DONE → sum/cout/overflow stable, in_ready=0, new in_valid ignored. Release → in_ready=1 next cycle.
- SERIAL_ADDER_SUB_EN defined; a=0x05, b=0x07, sub=1 → sum=0xFE, cout=0, overflow=0. Without the macro, same stimulus → sum=0x0C.
- Assert rst_n low at RUN beat 3 → out_valid stays 0, all outputs 0, in_ready=1 after release. The next operation (0x10+0x20) gives 0x30.
- WIDTH=16, STEP=4; a=0x1234, b=0x0FFF, cin=1 → out_valid 5 cycles after accept, sum=0x2234, cout=0.
